// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the five-stage control unit: opcodes, ALU op classes,
// the packed control word that travels down the pipe, and forward-select codes.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_ADDI = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_wr;
        logic       mem_rd;
        logic       mem2reg;
        logic       reg_wr;
        logic       pc_src_a;
        logic       lui;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode/funct3 decoder: control word, source-use flags and
// an illegal indication. Unknown opcodes yield an all-zero word.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output ctrl_t      ctrl_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R: begin
                ctrl_o.alu_op = ALUOP_FUNC;
                ctrl_o.reg_wr = 1'b1;
                use_rs1_o     = 1'b1;
                use_rs2_o     = 1'b1;
            end
            OP_IMM: begin
                ctrl_o.alu_op  = (funct3_i == 3'b000) ? ALUOP_ADDI : ALUOP_FUNC;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                use_rs1_o      = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o.alu_op  = ALUOP_ADD;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.mem_rd  = 1'b1;
                ctrl_o.mem2reg = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                use_rs1_o      = 1'b1;
            end
            OP_STORE: begin
                ctrl_o.alu_op  = ALUOP_ADD;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.mem_wr  = 1'b1;
                use_rs1_o      = 1'b1;
                use_rs2_o      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_o.alu_op = ALUOP_SUB;
                ctrl_o.branch = 1'b1;
                use_rs1_o     = 1'b1;
                use_rs2_o     = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.jump   = 1'b1;
                ctrl_o.reg_wr = 1'b1;
            end
            OP_JALR: begin
                ctrl_o.jump    = 1'b1;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
                use_rs1_o      = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.pc_src_a = 1'b1;
                ctrl_o.reg_wr   = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.lui     = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Five-stage pipeline control: decodes ID, carries control through ID/EX,
// EX/MEM and MEM/WB, and produces stall, flush and EX forward selects.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              ex_br_taken,
    output logic              stall_o,
    output logic              flush_o,
    output logic              illegal_o,
    output logic [10:0]       ex_ctrl_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o,
    output logic              wb_reg_wr_o,
    output logic              wb_mem2reg_o,
    output logic [REG_AW-1:0] wb_rd_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    ctrl_t             dec_ctrl;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic              dec_illegal;
    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              unused_funct7;

    ctrl_t             ex_ctrl_q,  ex_ctrl_d;
    logic [REG_AW-1:0] ex_rs1_q,   ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q,   ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
    logic              mem_wr_q,   mem_rd_q, mem_reg_wr_q, mem_mem2reg_q;
    logic [REG_AW-1:0] mem_rd_addr_q;
    logic              wb_reg_wr_q, wb_mem2reg_q;
    logic [REG_AW-1:0] wb_rd_q;

    logic hit_ex, hit_mem, load_use, raw_any, hazard, bubble_id;

    assign id_rd         = id_instr[7 +: REG_AW];
    assign id_rs1        = id_instr[15 +: REG_AW];
    assign id_rs2        = id_instr[20 +: REG_AW];
    assign unused_funct7 = ^id_instr[31:25];

    ctrl_decode u_decode (
        .opcode_i  (id_instr[6:0]),
        .funct3_i  (id_instr[14:12]),
        .ctrl_o    (dec_ctrl),
        .use_rs1_o (dec_use_rs1),
        .use_rs2_o (dec_use_rs2),
        .illegal_o (dec_illegal)
    );

    // A used, non-x0 ID source matching a given destination.
    function automatic logic src_hit(input logic [REG_AW-1:0] dst);
        return (dst != REG_ZERO) &&
               ((dec_use_rs1 && id_rs1 == dst) || (dec_use_rs2 && id_rs2 == dst));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (mem_reg_wr_q && rs != REG_ZERO && rs == mem_rd_addr_q)
            return FWD_MEM;
        else if (wb_reg_wr_q && rs != REG_ZERO && rs == wb_rd_q)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        hit_ex    = src_hit(ex_rd_q);
        hit_mem   = src_hit(mem_rd_addr_q);
        load_use  = id_valid && ex_ctrl_q.mem_rd && hit_ex;
        raw_any   = id_valid && ((ex_ctrl_q.reg_wr && hit_ex) || (mem_reg_wr_q && hit_mem));
        hazard    = FWD_EN ? load_use : raw_any;
        bubble_id = !id_valid || hazard || ex_br_taken;
    end

    // Unused sources are stored as x0 so they can never select a forward.
    always_comb begin
        ex_ctrl_d = CTRL_BUBBLE;
        ex_rs1_d  = REG_ZERO;
        ex_rs2_d  = REG_ZERO;
        ex_rd_d   = REG_ZERO;
        if (!bubble_id) begin
            ex_ctrl_d = dec_ctrl;
            ex_rs1_d  = dec_use_rs1 ? id_rs1 : REG_ZERO;
            ex_rs2_d  = dec_use_rs2 ? id_rs2 : REG_ZERO;
            ex_rd_d   = dec_ctrl.reg_wr ? id_rd : REG_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl_q     <= CTRL_BUBBLE;
            ex_rs1_q      <= REG_ZERO;
            ex_rs2_q      <= REG_ZERO;
            ex_rd_q       <= REG_ZERO;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_reg_wr_q  <= 1'b0;
            mem_mem2reg_q <= 1'b0;
            mem_rd_addr_q <= REG_ZERO;
            wb_reg_wr_q   <= 1'b0;
            wb_mem2reg_q  <= 1'b0;
            wb_rd_q       <= REG_ZERO;
        end else begin
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            mem_wr_q      <= ex_ctrl_q.mem_wr;
            mem_rd_q      <= ex_ctrl_q.mem_rd;
            mem_reg_wr_q  <= ex_ctrl_q.reg_wr;
            mem_mem2reg_q <= ex_ctrl_q.mem2reg;
            mem_rd_addr_q <= ex_rd_q;
            wb_reg_wr_q   <= mem_reg_wr_q;
            wb_mem2reg_q  <= mem_mem2reg_q;
            wb_rd_q       <= mem_rd_addr_q;
        end
    end

    assign stall_o      = hazard && !ex_br_taken;
    assign flush_o      = ex_br_taken;
    assign illegal_o    = id_valid && dec_illegal;
    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_rd_o      = ex_rd_q;
    assign fwd_a_o      = FWD_EN ? fwd_sel(ex_rs1_q) : FWD_RF;
    assign fwd_b_o      = FWD_EN ? fwd_sel(ex_rs2_q) : FWD_RF;
    assign mem_wr_o     = mem_wr_q;
    assign mem_rd_o     = mem_rd_q;
    assign wb_reg_wr_o  = wb_reg_wr_q;
    assign wb_mem2reg_o = wb_mem2reg_q;
    assign wb_rd_o      = wb_rd_q;

endmodule
